win3x3_frame_ctrl: RTL

- Frame sequencer for the 3x3 line-buffer window generator used by the gradient/Sobel stages of the Canny pipeline.
- Accepts one frame of WIDTH x DEPTH pixels over a valid/ready handshake and drives the line-buffer shift enable.
- After the last real pixel, injects WIDTH+1 padding shifts so every pixel gets a window centred on it.
- Tags each window with its centre row/column, a border flag and a frame-done pulse.

---
 rtl/win3x3_frame_ctrl.sv | 137 +++++++++++++
 1 files changed

// File: rtl/win3x3_frame_ctrl.sv
// Frame sequencer for the 3x3 line-buffer window generator: paces pixel intake,
// injects trailing pad shifts and tags every completed window with its centre.
module win3x3_frame_ctrl #(
  parameter int WIDTH   = 638,
  parameter int DEPTH   = 510,
  parameter int CNT_W   = 20,
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic               frame_start,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic               out_ready,
  output logic               shift_en,
  output logic               pad_sel,
  output logic               win_valid,
  output logic [COORD_W-1:0] win_row,
  output logic [COORD_W-1:0] win_col,
  output logic               border,
  output logic               frame_done,
  output logic               busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0]   LAST_PIX   = CNT_W'(WIDTH * DEPTH - 1);
  localparam logic [CNT_W-1:0]   LAST_SHIFT = CNT_W'(WIDTH * DEPTH + WIDTH);
  localparam logic [CNT_W-1:0]   FIRST_WIN  = CNT_W'(WIDTH + 1);
  localparam logic [COORD_W-1:0] LAST_COL   = COORD_W'(WIDTH - 1);
  localparam logic [COORD_W-1:0] LAST_ROW   = COORD_W'(DEPTH - 1);

  state_t             state, state_nxt;
  logic               shift, in_rdy, pad, win_fire;
  logic [CNT_W-1:0]   s_p0;
  logic [COORD_W-1:0] row_p0, col_p0;
  logic               vld_p1, border_p1, done_p1;
  logic [COORD_W-1:0] row_p1, col_p1;

  function automatic logic is_border(input logic [COORD_W-1:0] r,
                                     input logic [COORD_W-1:0] c);
    return (r == '0) || (r == LAST_ROW) || (c == '0) || (c == LAST_COL);
  endfunction

  always_comb begin
    state_nxt = state;
    shift     = 1'b0;
    in_rdy    = 1'b0;
    pad       = 1'b0;
    if (!en) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE: if (frame_start) state_nxt = RUN;
        RUN: begin
          in_rdy = out_ready;
          shift  = in_valid && out_ready;
          if (shift && (s_p0 == LAST_PIX)) state_nxt = FLUSH;
        end
        FLUSH: begin
          pad   = 1'b1;
          shift = out_ready;
          if (shift && (s_p0 == LAST_SHIFT)) state_nxt = DONE;
        end
        DONE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // A shift completes a window once the line buffers hold WIDTH+1 samples past its centre
  assign win_fire = shift && (s_p0 >= FIRST_WIN);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Stage p0: shift index and centre coordinates of the next window to complete
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      s_p0   <= '0;
      row_p0 <= '0;
      col_p0 <= '0;
    end else if ((state == IDLE) && frame_start) begin
      s_p0   <= '0;
      row_p0 <= '0;
      col_p0 <= '0;
    end else if (shift) begin
      s_p0 <= s_p0 + CNT_W'(1);
      if (win_fire) begin
        if (col_p0 == LAST_COL) begin
          col_p0 <= '0;
          row_p0 <= (row_p0 == LAST_ROW) ? '0 : row_p0 + COORD_W'(1);
        end else begin
          col_p0 <= col_p0 + COORD_W'(1);
        end
      end
    end
  end

  // Stage p1: registered window tag presented alongside the window registers
  always_ff @(posedge clk) begin
    if (rst || !en) begin
      vld_p1    <= 1'b0;
      border_p1 <= 1'b0;
      done_p1   <= 1'b0;
      row_p1    <= '0;
      col_p1    <= '0;
    end else begin
      vld_p1    <= win_fire;
      border_p1 <= win_fire && is_border(row_p0, col_p0);
      done_p1   <= win_fire && (s_p0 == LAST_SHIFT);
      if (win_fire) begin
        row_p1 <= row_p0;
        col_p1 <= col_p0;
      end
    end
  end

  assign shift_en   = shift;
  assign in_ready   = in_rdy;
  assign pad_sel    = pad;
  assign busy       = (state != IDLE);
  assign win_valid  = vld_p1;
  assign win_row    = row_p1;
  assign win_col    = col_p1;
  assign border     = border_p1;
  assign frame_done = done_p1;

endmodule
